// File: rtl/dma_pkg.sv
// dma_pkg: shared types, register offsets and control/status bit positions for the DMA engine
package dma_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dma_engine.sv
// dma_engine: word-copy DMA with a register responder port and a bus initiator port
import dma_pkg::*;
module dma_engine #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in,
  input  logic        fault_in,
  output logic        irq_out
);
  state_t state, next_state;
  logic [31:0] src, dst, data, rmux, wnew;
  logic [LEN_WIDTH-1:0] len;
  logic done, err, abort_req;
  logic busy, wr, start, abort_w, clear, len_last;
  logic [1:0] idx;
  assign busy = state != IDLE;
  assign idx = address_in[3:2];
  assign wr = sel_in && |write_mask_in;
  assign start = wr && idx == REG_CTRL && write_mask_in[0] && write_value_in[CTRL_START];
  assign abort_w = wr && idx == REG_CTRL && write_mask_in[0] && write_value_in[CTRL_ABORT];
  assign clear = wr && idx == REG_CTRL && write_mask_in[0] && write_value_in[CTRL_CLEAR];
  assign len_last = len == LEN_WIDTH'(1);
  assign rmux = idx == REG_SRC ? src :
                idx == REG_DST ? dst :
                idx == REG_LEN ? {{(32-LEN_WIDTH){1'b0}}, len} :
                {29'b0, err, done, busy};
  assign wnew = byte_merge(rmux, write_value_in, write_mask_in);
  assign read_value_out = sel_in ? rmux : 32'b0;
  assign ready_out = sel_in;
  assign irq_out = done | err;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  // next state and initiator request outputs; a request is held until ready_in
  always_comb begin
    next_state = state;
    read_out = 1'b0;
    write_out = 1'b0;
    address_out = 32'b0;
    write_mask_out = 4'b0;
    write_value_out = 32'b0;
    case (state)
      IDLE: next_state = (start && len != '0) ? READ : IDLE;
      READ: begin
        read_out = 1'b1;
        address_out = src;
        if (ready_in) next_state = (fault_in || abort_req) ? IDLE : WRITE;
      end
      WRITE: begin
        write_out = 1'b1;
        address_out = dst;
        write_mask_out = 4'b1111;
        write_value_out = data;
        if (ready_in) next_state = (fault_in || abort_req || len_last) ? IDLE : READ;
      end
      default: next_state = IDLE;
    endcase
  end
  // register file, transfer counters, data latch and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      src <= 32'b0;
      dst <= 32'b0;
      len <= '0;
      data <= 32'b0;
      done <= 1'b0;
      err <= 1'b0;
      abort_req <= 1'b0;
    end else begin
      if (!busy && wr && idx == REG_SRC) src <= {wnew[31:2], 2'b00};
      if (!busy && wr && idx == REG_DST) dst <= {wnew[31:2], 2'b00};
      if (!busy && wr && idx == REG_LEN) len <= wnew[LEN_WIDTH-1:0];
      if (!busy && start) begin
        done <= len == '0;
        err <= 1'b0;
      end else if (!busy && clear) begin
        done <= 1'b0;
        err <= 1'b0;
      end
      if (next_state == IDLE) abort_req <= 1'b0;
      else if (abort_w) abort_req <= 1'b1;
      if (state == READ && ready_in && !fault_in) data <= read_value_in;
      if (state == WRITE && ready_in && !fault_in) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len - LEN_WIDTH'(1);
        done <= len_last && !abort_req;
      end
      if (busy && ready_in && fault_in) begin
        err <= 1'b1;
        done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed register vectors plus multi-cycle transfer scenarios against a bus memory model
module tb_dma_engine;
  logic clk, reset;
  logic [31:0] address_in, read_value_out, write_value_in, address_out, read_value_in, write_value_out;
  logic sel_in, read_in, ready_out, read_out, write_out, ready_in, fault_in, irq_out;
  logic [3:0] write_mask_in, write_mask_out;
  int checks = 0, failures = 0;
  int rd_done, wr_done, wait_cnt, req_cnt, both_hi;
  int stall_rd, stall_wr, stall_n;
  logic [31:0] wmem [0:1023];
  logic [31:0] rd_addr [0:15];

  dma_engine dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .ready_out(ready_out), .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .read_value_in(read_value_in), .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .ready_in(ready_in), .fault_in(fault_in), .irq_out(irq_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // memory model: read data is a pattern of the address, 0x0005_xxxx faults, selected beats stall
  always_comb begin
    read_value_in = pat(address_out);
    fault_in = (read_out || write_out) && address_out[31:16] == 16'h0005;
    ready_in = (read_out || write_out) &&
               !(((read_out && rd_done == stall_rd) || (write_out && wr_done == stall_wr)) && wait_cnt < stall_n);
  end

  always @(posedge clk) begin
    if (reset) begin
      rd_done <= 0; wr_done <= 0; wait_cnt <= 0; req_cnt <= 0; both_hi <= 0;
    end else begin
      if (read_out || write_out) req_cnt <= req_cnt + 1;
      if (read_out && write_out) both_hi <= both_hi + 1;
      if ((read_out || write_out) && !ready_in) wait_cnt <= wait_cnt + 1;
      if (ready_in) begin
        wait_cnt <= 0;
        if (read_out) begin
          rd_addr[rd_done[3:0]] <= address_out;
          rd_done <= rd_done + 1;
        end
        if (write_out) begin
          wr_done <= wr_done + 1;
          if (!fault_in && write_mask_out == 4'b1111) wmem[address_out[11:2]] <= write_value_out;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1; sel_in = 0; read_in = 0; address_in = 0; write_mask_in = 0; write_value_in = 0;
    stall_rd = -1; stall_wr = -1; stall_n = 0;
    tick; tick;
    reset = 0;
  endtask

  task automatic wreg(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] m);
    sel_in = 1; address_in = {28'h0004_000, idx, 2'b00}; write_mask_in = m; write_value_in = d;
    tick;
    sel_in = 0; write_mask_in = 0; write_value_in = 0;
  endtask

  task automatic rreg(input logic [1:0] idx, output logic [31:0] v);
    sel_in = 1; read_in = 1; address_in = {28'h0004_000, idx, 2'b00};
    #1;
    v = read_value_out;
    sel_in = 0; read_in = 0;
    #1;
  endtask

  task automatic wait_quiet(input string nm, output int n);
    n = 0;
    while ((read_out || write_out) && n < 200) begin
      tick;
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] wd;
    logic [3:0]  m;
    logic [31:0] exp;
  } vec_t;
  vec_t v [8];

  initial begin
    logic [31:0] r;
    int n, bad;
    v[0] = '{2'd0, 32'h1234_5677, 4'hF, 32'h1234_5674};
    v[1] = '{2'd0, 32'hAABB_CCDD, 4'h2, 32'h1234_CC74};
    v[2] = '{2'd1, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFC};
    v[3] = '{2'd1, 32'h0000_0055, 4'h9, 32'h00FF_FF54};
    v[4] = '{2'd2, 32'hABCD_1234, 4'hF, 32'h0000_1234};
    v[5] = '{2'd2, 32'h0077_0000, 4'h4, 32'h0000_1234};
    v[6] = '{2'd2, 32'h0000_5600, 4'h2, 32'h0000_5634};
    v[7] = '{2'd3, 32'h0000_0004, 4'h1, 32'h0000_0000};

    do_reset;
    chk("reset_outputs", {read_out, write_out, write_mask_out, irq_out, 1'b0, address_out | write_value_out | read_value_out},
        37'h0);
    rreg(2'd3, r); chk("reset_status", r, 32'h0);
    rreg(2'd0, r); chk("reset_src", r, 32'h0);
    rreg(2'd2, r); chk("reset_len", r, 32'h0);
    chk("ready_follows_sel", {31'b0, ready_out}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      wreg(v[i].idx, v[i].wd, v[i].m);
      rreg(v[i].idx, r);
      chk($sformatf("vec%0d", i), r, v[i].exp);
    end
    chk("vec_no_request", 32'(req_cnt), 32'd0);

    do_reset;
    wreg(2'd0, 32'h100, 4'hF); wreg(2'd1, 32'h200, 4'hF); wreg(2'd2, 32'd4, 4'hF);
    wreg(2'd3, 32'h1, 4'h1);
    chk("start_latency", {read_out, address_out}, {1'b1, 32'h100});
    n = 0;
    while (!irq_out && n < 100) begin tick; n++; end
    chk("copy_cycles", 32'(n), 32'd8);
    chk("copy_beats", {16'(rd_done), 16'(wr_done)}, {16'd4, 16'd4});
    bad = 0;
    for (int i = 0; i < 4; i++) if (wmem[128 + i] !== pat(32'h100 + 32'(4 * i))) bad++;
    chk("copy_data_bad", 32'(bad), 32'd0);
    rreg(2'd3, r); chk("copy_status", r, 32'b010);
    rreg(2'd0, r); chk("copy_src_live", r, 32'h110);
    rreg(2'd2, r); chk("copy_len_live", r, 32'h0);
    wreg(2'd3, 32'h4, 4'h1);
    chk("clear_irq", {31'b0, irq_out}, 32'h0);

    do_reset;
    wreg(2'd2, 32'd0, 4'hF); wreg(2'd3, 32'h1, 4'h1);
    rreg(2'd3, r); chk("len0_status", r, 32'b010);
    chk("len0_irq", {31'b0, irq_out}, 32'h1);
    repeat (4) tick;
    chk("len0_no_beat", 32'(req_cnt), 32'd0);

    do_reset;
    wreg(2'd0, 32'h0005_0000, 4'hF); wreg(2'd1, 32'h200, 4'hF); wreg(2'd2, 32'd3, 4'hF);
    wreg(2'd3, 32'h1, 4'h1);
    wait_quiet("fault", n);
    rreg(2'd3, r); chk("fault_status", r, 32'b100);
    rreg(2'd0, r); chk("fault_src", r, 32'h0005_0000);
    rreg(2'd2, r); chk("fault_len", r, 32'd3);
    chk("fault_no_write", 32'(wr_done), 32'd0);

    do_reset;
    stall_rd = 1; stall_n = 5;
    wreg(2'd0, 32'h100, 4'hF); wreg(2'd1, 32'h300, 4'hF); wreg(2'd2, 32'd3, 4'hF);
    wreg(2'd3, 32'h1, 4'h1);
    n = 0;
    while (!(read_out && rd_done == 1) && n < 50) begin tick; n++; end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(read_out && !write_out && !ready_in && address_out == 32'h104)) bad++;
      tick;
    end
    chk("stall_hold_bad", 32'(bad), 32'd0);
    chk("stall_release", {read_out, ready_in, address_out}, {2'b11, 32'h104});
    wait_quiet("stall", n);
    bad = 0;
    for (int i = 0; i < 3; i++) if (wmem[192 + i] !== pat(32'h100 + 32'(4 * i))) bad++;
    chk("stall_data_bad", 32'(bad), 32'd0);
    rreg(2'd3, r); chk("stall_status", r, 32'b010);

    do_reset;
    stall_wr = 2; stall_n = 4;
    wreg(2'd0, 32'h100, 4'hF); wreg(2'd1, 32'h400, 4'hF); wreg(2'd2, 32'd8, 4'hF);
    wreg(2'd3, 32'h1, 4'h1);
    n = 0;
    while (!(write_out && wr_done == 2) && n < 50) begin tick; n++; end
    chk("abort_reach_stall", {write_out, ready_in}, 2'b10);
    wreg(2'd3, 32'h2, 4'h1);
    chk("abort_not_dropped", {31'b0, write_out}, 32'h1);
    wait_quiet("abort", n);
    chk("abort_writes", 32'(wr_done), 32'd3);
    rreg(2'd2, r); chk("abort_len", r, 32'd5);
    rreg(2'd3, r); chk("abort_status", r, 32'b000);
    rreg(2'd0, r); chk("abort_src", r, 32'h10C);
    n = req_cnt;
    repeat (3) tick;
    chk("abort_stays_idle", 32'(req_cnt), 32'(n));

    do_reset;
    wreg(2'd0, 32'hFFFF_FFFC, 4'hF); wreg(2'd1, 32'h600, 4'hF); wreg(2'd2, 32'd2, 4'hF);
    wreg(2'd3, 32'h1, 4'h1);
    wreg(2'd0, 32'h500, 4'hF);
    wreg(2'd2, 32'd9, 4'hF);
    wait_quiet("wrap", n);
    chk("wrap_rd1_addr", rd_addr[1], 32'h0);
    rreg(2'd0, r); chk("wrap_src_busy_wr", r, 32'h4);
    rreg(2'd2, r); chk("wrap_len_busy_wr", r, 32'h0);
    chk("wrap_data", wmem[385], pat(32'h0));
    chk("never_both_req", 32'(both_hi), 32'd0);

    do_reset;
    wreg(2'd0, 32'h100, 4'hF); wreg(2'd1, 32'h200, 4'hF); wreg(2'd2, 32'd4, 4'hF);
    wreg(2'd3, 32'h1, 4'h1);
    tick;
    reset = 1;
    tick;
    reset = 0;
    chk("midreset_req", {30'b0, read_out, write_out}, 32'h0);
    rreg(2'd3, r); chk("midreset_status", r, 32'h0);
    rreg(2'd1, r); chk("midreset_dst", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
